// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // IDLE: nothing in flight; BUSY: one live response owed; DROP: one stale response owed
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // A new request may go out only if the buffered words plus the responses still
  // owed after this cycle leave room for one more word in the 2-entry buffer.
  function automatic logic credit_ok(input logic [1:0] occ_after, input logic owed_after);
    return ({1'b0, occ_after} + {2'b00, owed_after}) <= 3'd1;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// 2-entry FIFO of {instr, pc} feeding the IF/ID register; head shown combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller's credit check keeps it from overflowing.
module if_fetch_unit_fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int WIDTH = INSTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_instr,
  input  logic [WIDTH-1:0] push_pc,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_instr,
  output logic [WIDTH-1:0] head_pc
);

  logic [WIDTH-1:0] instr_mem [0:1];
  logic [WIDTH-1:0] pc_mem    [0:1];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_d;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Occupancy after this cycle's accepted push/pop
  always_comb begin
    cnt_d = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt + 2'd1;
      2'b01:   cnt_d = cnt - 2'd1;
      default: cnt_d = cnt;
    endcase
  end

  // Pointers and count; flush empties the buffer and takes priority over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push) wr_ptr <= ~wr_ptr;
      cnt <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != 2'd0);
  assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, buffers responses for IF/ID.
// Latency: req at cycle 0, rvalid at 1, head valid at 2 with a zero-wait memory.
// Backpressure: stall_i holds the head; requests throttle on buffer credit, 1 in flight max.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = INSTR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] W_IF_instr_o,
  output logic [WIDTH-1:0] W_IF_PC_o,
  output logic             W_IF_valid_o
);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] inflight_pc_q;

  logic [1:0]       buf_count;
  logic             buf_valid;
  logic             pop;
  logic             push;
  logic             owed_after;
  logic [1:0]       occ_after;
  logic             req;
  logic             gnt_acc;

  // Head leaves when IF/ID consumes it; a redirect flushes regardless
  assign pop  = buf_valid && !stall_i;

  // Only a response to a live (BUSY) request is kept, and never in a redirect cycle
  assign push = imem_rvalid_i && (state_q == ST_BUSY) && !redirect_i;

  // A response is still owed after this cycle if one is outstanding and did not arrive now
  assign owed_after = (state_q != ST_IDLE) && !imem_rvalid_i;

  // Buffer occupancy once this cycle's pop/push/flush have landed
  assign occ_after = redirect_i ? 2'd0
                   : (buf_count - {1'b0, pop} + {1'b0, push});

  // Request rule: never while a response is owed, never from DROP (not even as
  // the stale word lands), and only with room for the word it will bring back.
  // The request being issued is not itself counted against the credit.
  assign req     = !rst && (state_q != ST_DROP) && !owed_after
                && credit_ok(occ_after, owed_after);
  assign gnt_acc = req && imem_gnt_i;

  // Next-state and PC update; redirect overrides and parks the FSM in DROP if
  // any response (old or just granted) is still owed
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: if (gnt_acc) state_d = ST_BUSY;
      ST_BUSY: if (imem_rvalid_i) state_d = gnt_acc ? ST_BUSY : ST_IDLE;
      ST_DROP: if (imem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (gnt_acc) pc_d = pc_q + WIDTH'(4);
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      state_d = (gnt_acc || owed_after) ? ST_DROP : ST_IDLE;
    end
  end

  // FSM and PC registers; in-flight PC tags the word when it returns
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (gnt_acc) inflight_pc_q <= pc_q;
    end
  end

  if_fetch_unit_fetch_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .push       (push),
    .push_instr (imem_rdata_i),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .count      (buf_count),
    .head_valid (buf_valid),
    .head_instr (W_IF_instr_o),
    .head_pc    (W_IF_PC_o)
  );

  assign W_IF_valid_o = buf_valid;
  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a program-order stream model and a memory model.
// Latency: checks req at cycle 0 and head valid at cycle 2 after reset with zero-wait memory.
// Backpressure: drives stall_i and delayed gnt; checks hold, credit and one-in-flight rules.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] W_IF_instr_o;
  logic [31:0] W_IF_PC_o;
  logic        W_IF_valid_o;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .W_IF_instr_o  (W_IF_instr_o),
    .W_IF_PC_o     (W_IF_PC_o),
    .W_IF_valid_o  (W_IF_valid_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rel = 0;
  int consumed = 0;
  logic phase_a = 1'b0;

  // stimulus for the next cycle
  logic        s_rst = 1'b1;
  logic        s_stall = 1'b0;
  logic        s_redir = 1'b0;
  logic [31:0] s_tgt = '0;
  logic        s_gnt = 1'b1;
  int          s_lat = 1;

  // memory model: granted addresses with the cycle their data is due
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // program-order model: next PC IF/ID should see, next address to be fetched
  logic [31:0] exp_pc = RPC;
  logic [31:0] fetch_exp = RPC;

  // previous-cycle observations
  logic        p_rst = 1'b1;
  logic        p_stall = 1'b0;
  logic        p_redir = 1'b0;
  logic        p_valid = 1'b0;
  logic [31:0] p_pc = '0;
  logic [31:0] p_instr = '0;
  logic        p_req = 1'b0;
  logic        p_gnt = 1'b0;
  logic [31:0] p_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst           = s_rst;
    stall_i       = s_stall;
    redirect_i    = s_redir;
    redirect_pc_i = s_tgt;
    imem_gnt_i    = s_gnt;
    if (!s_rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    if (s_rst) begin
      check("req_in_rst", 32'(imem_req_o), 32'd0);
      pend_addr.delete();
      pend_due.delete();
      exp_pc    = RPC;
      fetch_exp = RPC;
      rel       = 0;
    end else begin
      if (p_rst) begin
        check("rst_vld",   32'(W_IF_valid_o), 32'd0);
        check("rst_instr", W_IF_instr_o, 32'd0);
        check("rst_pc",    W_IF_PC_o, 32'd0);
        check("rst_req",   32'(imem_req_o), 32'd1);
        check("rst_addr",  imem_addr_o, RPC);
      end else if (p_redir) begin
        check("flush_vld", 32'(W_IF_valid_o), 32'd0);
      end
      if (p_stall && p_valid && !p_redir && !p_rst) begin
        check("hold_vld",   32'(W_IF_valid_o), 32'd1);
        check("hold_pc",    W_IF_PC_o, p_pc);
        check("hold_instr", W_IF_instr_o, p_instr);
      end
      if (p_req && !p_gnt && imem_req_o && !p_redir && !p_rst)
        check("req_hold", imem_addr_o, p_addr);
      if (phase_a) begin
        if (rel == 1) check("lat_vld1", 32'(W_IF_valid_o), 32'd0);
        if (rel >= 2) check("stream_vld", 32'(W_IF_valid_o), 32'd1);
      end
      if (W_IF_valid_o && !s_stall && !s_redir) begin
        check("pc", W_IF_PC_o, exp_pc);
        check("instr", W_IF_instr_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (imem_rvalid_i) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req_o && s_gnt) begin
        check("fetch_addr", imem_addr_o, fetch_exp);
        check("one_inflight", 32'(pend_addr.size()), 32'd0);
        pend_addr.push_back(imem_addr_o);
        pend_due.push_back(cyc + s_lat);
        fetch_exp = fetch_exp + 32'd4;
      end
      if (s_redir) begin
        exp_pc    = s_tgt;
        fetch_exp = s_tgt;
      end
      rel++;
    end
    p_rst   = s_rst;
    p_stall = s_stall;
    p_redir = s_redir;
    p_valid = W_IF_valid_o;
    p_pc    = W_IF_PC_o;
    p_instr = W_IF_instr_o;
    p_req   = imem_req_o;
    p_gnt   = s_gnt;
    p_addr  = imem_addr_o;
    cyc++;
  endtask

  initial begin
    // reset then zero-wait streaming
    phase_a = 1'b1;
    repeat (3) step();
    s_rst = 1'b0;
    repeat (30) step();
    phase_a = 1'b0;

    // 5-cycle stall mid-stream: buffer fills, requests stop
    for (int i = 0; i < 5; i++) begin
      s_stall = 1'b1;
      step();
      if (i >= 1) check("stall_noreq", 32'(p_req), 32'd0);
    end
    s_stall = 1'b0;
    repeat (6) step();

    // grant withheld for 3 cycles, repeatedly
    for (int r = 0; r < 3; r++) begin
      s_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        check("gnt_wait_req", 32'(p_req), 32'd1);
      end
      s_gnt = 1'b1;
      step();
    end
    repeat (4) step();

    // redirect while a response is outstanding
    s_redir = 1'b1;
    s_tgt   = 32'h8000_0100;
    step();
    s_redir = 1'b0;
    repeat (10) step();

    // redirect coincident with rvalid and stall
    s_stall = 1'b1;
    s_redir = 1'b1;
    s_tgt   = 32'h0000_2000;
    step();
    s_redir = 1'b0;
    s_stall = 1'b0;
    repeat (8) step();

    // reset with a full buffer and a request in flight
    s_stall = 1'b1;
    repeat (2) step();
    s_rst = 1'b1;
    step();
    s_rst   = 1'b0;
    s_stall = 1'b0;
    repeat (8) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_stall = ($urandom_range(0, 9) < 3);
      s_redir = ($urandom_range(0, 24) == 0);
      s_tgt   = $urandom & 32'hFFFF_FFFC;
      s_gnt   = ($urandom_range(0, 9) < 6);
      s_lat   = $urandom_range(1, 3);
      step();
    end

    check("progress", 32'(consumed > 200), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
